sfr_timer: RTL and testbench



---
 rtl/sfr_timer_pkg.sv | 25 ++
 rtl/timer_prescaler.sv | 35 +++
 rtl/sfr_timer.sv | 96 +++++++++
 tb/tb_sfr_timer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_timer_pkg.sv
// Shared constants for the SFR interval timer: word widths, ctrl bit
// positions, status bit positions and the FSM state encoding.
package sfr_timer_pkg;

  localparam int SFR_W      = 12;
  localparam int SFR_PSEL_W = 4;
  localparam int PCNT_W     = 15;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_AR       = 1;
  localparam int CTRL_PSEL_LSB = 2;
  localparam int CTRL_PSEL_MSB = 5;
  localparam int CTRL_INTEN    = 6;

  localparam int STAT_FLAG      = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_STATE_MSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the SFR timer: produces one tick every 2^psel clocks
// while run is high, and holds its counter at zero otherwise.
module timer_prescaler #(
  parameter int PSEL_W = 4,
  parameter int PCNT_W = 15
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              run,
  input  logic [PSEL_W-1:0] psel,
  output logic              tick
);

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] threshold;

  // Threshold is 2^psel - 1; psel=15 wraps the shift to 0 so the
  // subtraction yields all ones (one tick per 32768 clocks).
  assign threshold = (PCNT_W'(1) << psel) - PCNT_W'(1);
  assign tick      = run && (pcnt == threshold);

  // Free-running divide counter, cleared whenever the timer is not running.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pcnt <= '0;
    end else if (!run) begin
      pcnt <= '0;
    end else if (pcnt == threshold) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

endmodule

// File: rtl/sfr_timer.sv
// Programmable interval timer peripheral driven from SFR words. Counts
// prescaled ticks up to the live period value, sets a sticky expiry flag
// and raises a one-cycle interrupt request on each expiry.
module sfr_timer
  import sfr_timer_pkg::*;
#(
  parameter int DATA_W = SFR_W,
  parameter int PSEL_W = SFR_PSEL_W
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [DATA_W-1:0] ctrl,
  input  logic [DATA_W-1:0] period,
  input  logic              clr_flag,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] status,
  output logic              timer_int
);

  timer_state_t      state;
  logic              flag;
  logic              tick;
  logic              enable;
  logic              auto_reload;
  logic              int_en;
  logic [PSEL_W-1:0] psel;
  logic              run;

  assign enable      = ctrl[CTRL_EN];
  assign auto_reload = ctrl[CTRL_AR];
  assign int_en      = ctrl[CTRL_INTEN];
  assign psel        = ctrl[CTRL_PSEL_MSB:CTRL_PSEL_LSB];

  // Gating run with enable keeps a tick on the disable edge from
  // advancing the prescaler, so it lands at zero together with IDLE.
  assign run = (state == ST_RUN) && enable;

  timer_prescaler #(
    .PSEL_W (PSEL_W),
    .PCNT_W (PCNT_W)
  ) u_prescaler (
    .clock  (clock),
    .nreset (nreset),
    .run    (run),
    .psel   (psel),
    .tick   (tick)
  );

  assign status = {{(DATA_W-3){1'b0}}, state, flag};

  // Timer FSM with counter, sticky flag and registered interrupt pulse.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      count     <= '0;
      flag      <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      timer_int <= 1'b0;
      if (clr_flag) begin
        flag <= 1'b0;
      end
      if (!enable) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_RUN;
            count <= '0;
          end
          ST_RUN: begin
            if (tick) begin
              if (count >= period) begin
                count     <= '0;
                flag      <= 1'b1;
                timer_int <= int_en;
                state     <= auto_reload ? ST_RUN : ST_DONE;
              end else begin
                count <= count + DATA_W'(1);
              end
            end
          end
          ST_DONE: begin
            count <= '0;
          end
          default: begin
            state <= ST_IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfr_timer.sv
// Self-checking bench for sfr_timer: directed scenarios with literal
// expectations, then randomized SFR traffic compared every cycle against
// a behavioural model of the timer.
module tb_sfr_timer;

  logic        clock;
  logic        nreset;
  logic [11:0] ctrl;
  logic [11:0] period;
  logic        clr_flag;
  logic [11:0] count;
  logic [11:0] status;
  logic        timer_int;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: phase of operation, tick schedule derived from
  // elapsed run time modulo 2^psel, and plain counter/flag arithmetic.
  int m_state;
  int m_count;
  int m_flag;
  int m_int;
  int m_run_cycles;

  sfr_timer dut (
    .clock     (clock),
    .nreset    (nreset),
    .ctrl      (ctrl),
    .period    (period),
    .clr_flag  (clr_flag),
    .count     (count),
    .status    (status),
    .timer_int (timer_int)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] c, input logic [11:0] p, input logic clr);
    ctrl     = c;
    period   = p;
    clr_flag = clr;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Reference model update on every clock edge or asynchronous reset.
  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      m_state = 0; m_count = 0; m_flag = 0; m_int = 0; m_run_cycles = 0;
    end else begin
      int  div;
      bit  ticked;
      div    = 1 << ctrl[5:2];
      m_int  = 0;
      if (clr_flag) m_flag = 0;
      if (!ctrl[0]) begin
        m_state = 0; m_count = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_count = 0; m_run_cycles = 0;
      end else if (m_state == 1) begin
        m_run_cycles++;
        ticked = (m_run_cycles % div) == 0;
        if (ticked) begin
          if (m_count >= int'(period)) begin
            m_count = 0;
            m_flag  = 1;
            m_int   = ctrl[6] ? 1 : 0;
            m_state = ctrl[1] ? 1 : 2;
          end else begin
            m_count++;
          end
        end
      end else begin
        m_count = 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      checkOutput("model_count", 32'(count), 32'(m_count));
      checkOutput("model_status", 32'(status), 32'((m_state << 1) | m_flag));
      checkOutput("model_int", 32'(timer_int), 32'(m_int));
    end
  end

  initial begin
    int exp1[5] = '{0, 1, 2, 3, 0};
    bit found;

    nreset = 1'b0;
    applyStimulus(12'h000, 12'd0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("reset_count", 32'(count), 32'h0);
    checkOutput("reset_status", 32'(status), 32'h0);
    checkOutput("reset_int", 32'(timer_int), 32'h0);
    nreset = 1'b1;
    cmp_en = 1'b1;
    stepCycle();

    $display("[TB] one-shot, psel=0, period=3");
    applyStimulus(12'h001, 12'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("t1_count_%0d", k), 32'(count), 32'(exp1[k]));
      checkOutput($sformatf("t1_int_%0d", k), 32'(timer_int), 32'h0);
    end
    checkOutput("t1_status_done", 32'(status), 32'h005);
    stepCycle();
    checkOutput("t1_count_hold", 32'(count), 32'h0);
    checkOutput("t1_status_hold", 32'(status), 32'h005);

    $display("[TB] auto-reload with interrupt and flag races");
    applyStimulus(12'h000, 12'd3, 1'b0);
    stepCycle();
    checkOutput("t2_idle_flag", 32'(status), 32'h001);
    applyStimulus(12'h000, 12'd3, 1'b1);
    stepCycle();
    checkOutput("t2_cleared", 32'(status), 32'h000);
    applyStimulus(12'h043, 12'd2, 1'b0);
    stepCycle();
    checkOutput("t2_run_entry", 32'(status), 32'h002);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(12'h043, 12'd2, (k == 6 || k == 7));
      stepCycle();
      checkOutput($sformatf("t2_int_%0d", k), 32'(timer_int), 32'((k % 3) == 0));
      if (k == 3) checkOutput("t2_status_first", 32'(status), 32'h003);
      if (k == 6) checkOutput("t2_race_set_wins", 32'(status), 32'h003);
      if (k == 7) checkOutput("t2_clr_alone", 32'(status), 32'h002);
    end

    $display("[TB] prescaler psel=2, period=1");
    applyStimulus(12'h000, 12'd1, 1'b1);
    stepCycle();
    applyStimulus(12'h049, 12'd1, 1'b0);
    stepCycle();
    checkOutput("t3_entry", 32'(status), 32'h002);
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      checkOutput($sformatf("t3_count_%0d", k), 32'(count), (k >= 4 && k < 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t3_int_%0d", k), 32'(timer_int), 32'(k == 8));
      if (k >= 8) checkOutput($sformatf("t3_status_%0d", k), 32'(status), 32'h005);
    end

    $display("[TB] live period lowering");
    applyStimulus(12'h000, 12'd100, 1'b0);
    stepCycle();
    applyStimulus(12'h041, 12'd100, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      stepCycle();
      if (count == 12'd50) found = 1'b1;
    end
    checkOutput("t4_reached_50", 32'(found), 32'h1);
    applyStimulus(12'h041, 12'd10, 1'b0);
    stepCycle();
    checkOutput("t4_count", 32'(count), 32'h0);
    checkOutput("t4_int", 32'(timer_int), 32'h1);
    checkOutput("t4_status", 32'(status), 32'h005);

    $display("[TB] enable drop on expiry tick");
    applyStimulus(12'h000, 12'd3, 1'b0);
    stepCycle();
    applyStimulus(12'h041, 12'd3, 1'b0);
    repeat (4) stepCycle();
    checkOutput("t5_count_at_period", 32'(count), 32'h3);
    applyStimulus(12'h000, 12'd3, 1'b0);
    stepCycle();
    checkOutput("t5_int", 32'(timer_int), 32'h0);
    checkOutput("t5_count", 32'(count), 32'h0);
    checkOutput("t5_status", 32'(status), 32'h001);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(12'h041, 12'd100, 1'b0);
    repeat (6) stepCycle();
    checkOutput("t6_count_before", 32'(count), 32'h5);
    #2 nreset = 1'b0;
    #1;
    checkOutput("t6_count", 32'(count), 32'h0);
    checkOutput("t6_status", 32'(status), 32'h0);
    checkOutput("t6_int", 32'(timer_int), 32'h0);
    stepCycle();
    nreset = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] c;
      logic [11:0] p;
      int r;
      int r2;
      c  = ctrl;
      p  = period;
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      if (c[0]) begin
        if (r < 2) c[0] = 1'b0;
        else if (r < 4) c[1] = ~c[1];
        else if (r < 6) c[6] = ~c[6];
        else if (r < 8) c[11:7] = 5'($urandom);
      end else if (r < 25) begin
        c      = 12'($urandom);
        c[0]   = 1'b1;
        c[5:2] = 4'($urandom_range(0, 3));
      end
      if (r2 < 3) p = 12'($urandom_range(0, 20));
      else if (r2 == 3) p = 12'($urandom_range(0, 4095));
      applyStimulus(c, p, ($urandom_range(0, 9) == 0));
      stepCycle();
    end

    applyStimulus(12'h000, 12'd0, 1'b0);
    stepCycle();
    stepCycle();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
